boot_load_ctrl: RTL
===================

BOOT_LOAD_CTRL -- requirements
Module: boot_load_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 32, image word width (multiple of 8).
- ADDR_W, 14, SRAM word-address width.
- DEPTH, 16384, SRAM words (≤ 2^ADDR_W, ≥ 2).
- BIG_ENDIAN, 1, lane 0 = MSB when 1, lane 0 = LSB when 0.
- MAX_CYCLES, 30000000, run-phase timeout in clocks.
REQ-002 SHALL have ports, one per line (LANES = DATA_W/8):
- i_ext_pad_clkmux_ehs_clk  in  1  clock.
- PI_SOC_RST_B  in  1  reset, asynchronous, active-high.
- start  in  1  begin load; single-cycle pulse.
- src_valid  in  1  image word valid.
- src_data  in  DATA_W  image word.
- src_last  in  1  final image word.
- src_ready  out  1  word accepted when src_valid & src_ready.
- mem_we  out  LANES  per-lane write enable.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_wdata  out  DATA_W  lane-ordered write data; lane i = bits [8i+7:8i].
- cpu_rst_b  out  1  CPU reset, low = held.
- end_flag  in  1  program-complete indication.
- busy  out  1  state is LOAD, FILL or RUN.
- done, pass, fail, ovf  out  1 each  status flags.
- cycle_cnt  out  32  run-phase clock count.
- load_cnt  out  ADDR_W+1  image words accepted.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, FILL, RUN, DONE.
REQ-004 IDLE: src_ready=0, cpu_rst_b=0; start → LOAD, address counter=0, load_cnt=0, done/pass/fail/ovf cleared.
REQ-005 LOAD: src_ready=1; each accepted word: one write at current address, address+1, load_cnt+1.
REQ-006 Accepted word with src_last=1 at address < DEPTH-1 → FILL; at address = DEPTH-1 → RUN.
REQ-007 Accepted word at address DEPTH-1 without src_last → RUN, ovf=1 sticky; all later source words unaccepted (src_ready=0).
REQ-008 FILL: src_ready=0; one all-lanes zero write per clock at consecutive addresses up to and including DEPTH-1, then RUN.
REQ-009 Write outputs SHALL be registered: mem_we/mem_addr/mem_wdata valid the clock after acceptance (LOAD) or address issue (FILL); mem_we=0 on all other clocks.
REQ-010 Write strobe SHALL assert all LANES bits; lane mapping: BIG_ENDIAN=1 → lane i gets src_data[DATA_W-1-8i -: 8]; BIG_ENDIAN=0 → lane i gets src_data[8i+7:8i].
REQ-011 RUN: cpu_rst_b=1 from the first RUN clock (registered); cycle_cnt cleared on RUN entry, +1 per clock in RUN.
REQ-012 RUN exit: end_flag=1 → DONE, pass=1; cycle_cnt = MAX_CYCLES-1 → DONE, fail=1; both same clock → pass=1, fail=0.
REQ-013 DONE: cpu_rst_b=0, done=1, cycle_cnt frozen; start → LOAD with REQ-004 clearing.
REQ-014 start SHALL be ignored in LOAD, FILL, RUN; end_flag ignored outside RUN.
REQ-015 cycle_cnt SHALL saturate at 32'hFFFFFFFF, never wrap.
REQ-016 busy=1 exactly when state ∈ {LOAD, FILL, RUN}.

Reset
REQ-017 PI_SOC_RST_B=1 SHALL asynchronously force IDLE; all outputs 0 (cpu_rst_b=0, mem_we=0, src_ready=0, counters and flags 0).
REQ-018 Reset asserted mid-LOAD/FILL/RUN SHALL abort immediately; no further mem_we; flags not retained.
REQ-019 After deassertion, first state change only on start.

Verification
REQ-020 DEPTH=16, BIG_ENDIAN=1: start, 4 words 0x11223344..0x44556677, last on 4th → addr 0–3 written with lane0=0x11 etc., addr 4–15 zero, load_cnt=4, cpu_rst_b=1 one clock after addr-15 write.
REQ-021 BIG_ENDIAN=0, word 0xA1B2C3D4 → lane0=0xD4, lane3=0xA1; src_valid gaps of 3 clocks → no extra writes, addresses contiguous.
REQ-022 DEPTH=16, 20 words without src_last → 16 writes, ovf=1, src_ready=0 after 16th, no FILL writes.
REQ-023 MAX_CYCLES=100, no end_flag → fail=1, done=1, cycle_cnt=99, cpu_rst_b=0; end_flag on timeout clock in rerun → pass=1, fail=0.
REQ-024 Reset pulse during FILL at addr 8 → mem_we=0 immediately, state IDLE; start then completes full load normally.

Source files
------------

// File: rtl/boot_load_ctrl.sv
// Boot image loader: streams an image into SRAM, zero-fills the remainder,
// releases the CPU from reset and times the run until end_flag or timeout.
module boot_load_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 14,
  parameter int DEPTH      = 16384,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int MAX_CYCLES = 30000000
) (
  input  logic                    i_ext_pad_clkmux_ehs_clk,
  input  logic                    PI_SOC_RST_B,
  input  logic                    start,
  input  logic                    src_valid,
  input  logic [DATA_W-1:0]       src_data,
  input  logic                    src_last,
  output logic                    src_ready,
  output logic [DATA_W/8-1:0]     mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    cpu_rst_b,
  input  logic                    end_flag,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    ovf,
  output logic [31:0]             cycle_cnt,
  output logic [ADDR_W:0]         load_cnt
);

  localparam int                LANES     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]       CYC_LAST  = 32'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FILL = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
  logic [LANES-1:0]    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_b_q, cpu_rst_b_d;
  logic                src_ready_q, src_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic                accept_s;

  // Lane 0 is the most significant source byte when BIG_ENDIAN is set.
  function automatic logic [DATA_W-1:0] lane_map(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (BIG_ENDIAN) begin
        r[8*i +: 8] = d[DATA_W-1-8*i -: 8];
      end else begin
        r[8*i +: 8] = d[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign accept_s = src_valid & src_ready_q;

  // Next-state, write issue, counters and status flags.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    load_cnt_d  = load_cnt_q;
    mem_we_d    = {LANES{1'b0}};
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    ovf_d       = ovf_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          addr_d     = {ADDR_W{1'b0}};
          load_cnt_d = {(ADDR_W+1){1'b0}};
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          ovf_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          mem_we_d    = {LANES{1'b1}};
          mem_addr_d  = addr_q;
          mem_wdata_d = lane_map(src_data);
          load_cnt_d  = load_cnt_q + CNT_ONE;
          if (addr_q == LAST_ADDR) begin
            // Image filled the whole SRAM; a missing src_last means it was too long.
            state_d     = ST_RUN;
            cycle_cnt_d = 32'd0;
            ovf_d       = ovf_q | ~src_last;
          end else begin
            addr_d = addr_q + ADDR_ONE;
            if (src_last) begin
              state_d = ST_FILL;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FILL: begin
        mem_we_d    = {LANES{1'b1}};
        mem_addr_d  = addr_q;
        mem_wdata_d = {DATA_W{1'b0}};
        if (addr_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          cycle_cnt_d = 32'd0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        // end_flag wins a tie with the timeout; the count freezes on the exit clock.
        if (end_flag) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end else if (cycle_cnt_q == CYC_LAST) begin
          state_d = ST_DONE;
          fail_d  = 1'b1;
        end else if (cycle_cnt_q == 32'hFFFF_FFFF) begin
          cycle_cnt_d = cycle_cnt_q;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    src_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_FILL) || (state_d == ST_RUN);
    cpu_rst_b_d = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers, cleared asynchronously by the SoC reset.
  always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
    if (PI_SOC_RST_B) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      load_cnt_q  <= {(ADDR_W+1){1'b0}};
      mem_we_q    <= {LANES{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      cpu_rst_b_q <= 1'b0;
      src_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cycle_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      load_cnt_q  <= load_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_b_q <= cpu_rst_b_d;
      src_ready_q <= src_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ovf_q       <= ovf_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign src_ready = src_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_b = cpu_rst_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign ovf       = ovf_q;
  assign cycle_cnt = cycle_cnt_q;
  assign load_cnt  = load_cnt_q;

endmodule
